// File: rtl/mod_arith_pkg.sv
// Shared definitions for the sequential modular exponentiator:
// FSM state encoding and legal bounds for the WIDTH parameter.
package mod_arith_pkg;

    localparam int unsigned WIDTH_MIN = 8;
    localparam int unsigned WIDTH_MAX = 1024;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_SQUARE   = 2'd1,
        ST_MULTIPLY = 2'd2,
        ST_FINISH   = 2'd3
    } state_e;

endpackage

// File: rtl/mod_mult_serial.sv
// Bit-serial interleaved modular multiplier: p = a*b mod m in exactly WIDTH cycles.
// The first step is taken on the start edge straight from the inputs so back-to-back jobs chain without bubbles.
module mod_mult_serial #(
    parameter int unsigned WIDTH = 128
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [WIDTH-1:0] m,
    output logic             done,
    output logic [WIDTH-1:0] p
);

    localparam int unsigned EXT_W = WIDTH + 2;
    localparam int unsigned CNT_W = $clog2(WIDTH);

    logic [WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] m_q, m_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             run_q, run_d;
    logic             done_q, done_d;

    // acc, b < m, so 2*acc + b < 3m: two conditional subtractions restore acc < m
    function automatic logic [WIDTH-1:0] mac_step(
        input logic [WIDTH-1:0] acc_v,
        input logic             a_bit,
        input logic [WIDTH-1:0] b_v,
        input logic [WIDTH-1:0] m_v
    );
        logic [EXT_W-1:0] t;
        logic [EXT_W-1:0] mm;
        mm = EXT_W'(m_v);
        t  = {1'b0, acc_v, 1'b0} + (a_bit ? EXT_W'(b_v) : EXT_W'(0));
        if (t >= mm) t = t - mm;
        if (t >= mm) t = t - mm;
        return t[WIDTH-1:0];
    endfunction

    always_comb begin
        acc_d  = acc_q;
        a_d    = a_q;
        b_d    = b_q;
        m_d    = m_q;
        cnt_d  = cnt_q;
        run_d  = run_q;
        done_d = 1'b0;
        if (start) begin
            acc_d = mac_step(WIDTH'(0), a[WIDTH-1], b, m);
            a_d   = {a[WIDTH-2:0], 1'b0};
            b_d   = b;
            m_d   = m;
            cnt_d = CNT_W'(WIDTH - 1);
            run_d = 1'b1;
        end else if (run_q) begin
            acc_d = mac_step(acc_q, a_q[WIDTH-1], b_q, m_q);
            a_d   = {a_q[WIDTH-2:0], 1'b0};
            cnt_d = cnt_q - CNT_W'(1);
            if (cnt_q == CNT_W'(1)) begin
                run_d  = 1'b0;
                done_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc_q  <= '0;
            a_q    <= '0;
            b_q    <= '0;
            m_q    <= '0;
            cnt_q  <= '0;
            run_q  <= 1'b0;
            done_q <= 1'b0;
        end else begin
            acc_q  <= acc_d;
            a_q    <= a_d;
            b_q    <= b_d;
            m_q    <= m_d;
            cnt_q  <= cnt_d;
            run_q  <= run_d;
            done_q <= done_d;
        end
    end

    assign done = done_q;
    assign p    = acc_q;

endmodule

// File: rtl/mod_exp_seq.sv
// Sequential left-to-right square-and-multiply modular exponentiator built on mod_mult_serial.
// Define MOD_EXP_CONST_TIME_EN to run MULTIPLY for every exponent bit (fixed latency).
module mod_exp_seq
    import mod_arith_pkg::*;
#(
    parameter int unsigned WIDTH = 128
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] base,
    input  logic [WIDTH-1:0] exp,
    input  logic [WIDTH-1:0] mod,
    output logic             busy,
    output logic             done,
    output logic             err,
    output logic [WIDTH-1:0] result
);

    localparam int unsigned IDX_W = $clog2(WIDTH);

`ifdef MOD_EXP_CONST_TIME_EN
    localparam bit CONST_TIME = 1'b1;
`else
    localparam bit CONST_TIME = 1'b0;
`endif

    if (WIDTH < WIDTH_MIN || WIDTH > WIDTH_MAX) begin : g_width_check
        $error("mod_exp_seq: WIDTH outside legal range");
    end

    state_e           state_q, state_d;
    logic [WIDTH-1:0] base_q, base_d;
    logic [WIDTH-1:0] exp_q, exp_d;
    logic [WIDTH-1:0] mod_q, mod_d;
    logic [WIDTH-1:0] acc_q, acc_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             err_q, err_d;
    logic [WIDTH-1:0] result_q, result_d;

    logic             mult_start_c;
    logic [WIDTH-1:0] mult_a_c;
    logic [WIDTH-1:0] mult_b_c;
    logic [WIDTH-1:0] mult_m_c;
    logic             mult_done;
    logic [WIDTH-1:0] mult_p;
    logic             op_err_c;
    logic             cur_bit_c;

    mod_mult_serial #(
        .WIDTH (WIDTH)
    ) u_mult (
        .clk   (clk),
        .rst   (rst),
        .start (mult_start_c),
        .a     (mult_a_c),
        .b     (mult_b_c),
        .m     (mult_m_c),
        .done  (mult_done),
        .p     (mult_p)
    );

    // Next-state logic; each multiply is launched on the edge its predecessor's product is consumed
    always_comb begin
        state_d      = state_q;
        base_d       = base_q;
        exp_d        = exp_q;
        mod_d        = mod_q;
        acc_d        = acc_q;
        idx_d        = idx_q;
        busy_d       = busy_q;
        done_d       = 1'b0;
        err_d        = err_q;
        result_d     = result_q;
        mult_start_c = 1'b0;
        mult_a_c     = acc_q;
        mult_b_c     = acc_q;
        mult_m_c     = mod_q;
        op_err_c     = (mod < WIDTH'(2)) || (base >= mod);
        cur_bit_c    = exp_q[idx_q];

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    base_d   = base;
                    exp_d    = exp;
                    mod_d    = mod;
                    busy_d   = 1'b1;
                    result_d = '0;
                    idx_d    = IDX_W'(WIDTH - 1);
                    if (op_err_c) begin
                        err_d   = 1'b1;
                        acc_d   = '0;
                        state_d = ST_FINISH;
                    end else begin
                        err_d        = 1'b0;
                        acc_d        = WIDTH'(1);
                        state_d      = ST_SQUARE;
                        mult_start_c = 1'b1;
                        mult_a_c     = WIDTH'(1);
                        mult_b_c     = WIDTH'(1);
                        mult_m_c     = mod;
                    end
                end
            end

            ST_SQUARE: begin
                if (mult_done) begin
                    acc_d = mult_p;
                    if (CONST_TIME || cur_bit_c) begin
                        state_d      = ST_MULTIPLY;
                        mult_start_c = 1'b1;
                        mult_a_c     = mult_p;
                        mult_b_c     = base_q;
                    end else if (idx_q == IDX_W'(0)) begin
                        state_d = ST_FINISH;
                    end else begin
                        idx_d        = idx_q - IDX_W'(1);
                        mult_start_c = 1'b1;
                        mult_a_c     = mult_p;
                        mult_b_c     = mult_p;
                    end
                end
            end

            ST_MULTIPLY: begin
                if (mult_done) begin
                    // zero exponent bits only reach here in constant-time mode; their product is dropped
                    acc_d = cur_bit_c ? mult_p : acc_q;
                    if (idx_q == IDX_W'(0)) begin
                        state_d = ST_FINISH;
                    end else begin
                        idx_d        = idx_q - IDX_W'(1);
                        state_d      = ST_SQUARE;
                        mult_start_c = 1'b1;
                        mult_a_c     = acc_d;
                        mult_b_c     = acc_d;
                    end
                end
            end

            ST_FINISH: begin
                done_d   = 1'b1;
                busy_d   = 1'b0;
                result_d = acc_q;
                state_d  = ST_IDLE;
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            base_q   <= '0;
            exp_q    <= '0;
            mod_q    <= '0;
            acc_q    <= '0;
            idx_q    <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
            result_q <= '0;
        end else begin
            state_q  <= state_d;
            base_q   <= base_d;
            exp_q    <= exp_d;
            mod_q    <= mod_d;
            acc_q    <= acc_d;
            idx_q    <= idx_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            err_q    <= err_d;
            result_q <= result_d;
        end
    end

    assign busy   = busy_q;
    assign done   = done_q;
    assign err    = err_q;
    assign result = result_q;

endmodule

// File: doc/mod_exp_seq.md
MOD_EXP_SEQ -- requirements
Module: mod_exp_seq

Interface
REQ-001 SHALL have parameter WIDTH, default 128, operand/modulus bit width; legal range 8..1024.
REQ-002 SHALL have port clk  input  1  single clock, all state on rising edge.
REQ-003 SHALL have port rst  input  1  asynchronous, active-high reset.
REQ-004 SHALL have port start  input  1  request; sampled only in IDLE.
REQ-005 SHALL have port base  input  WIDTH  base operand, sampled with start.
REQ-006 SHALL have port exp  input  WIDTH  exponent, sampled with start.
REQ-007 SHALL have port mod  input  WIDTH  modulus, sampled with start.
REQ-008 SHALL have port busy  output  1  high from the cycle after start acceptance until done.
REQ-009 SHALL have port done  output  1  one-cycle completion pulse.
REQ-010 SHALL have port err  output  1  operand error, valid with done, held until next acceptance.
REQ-011 SHALL have port result  output  WIDTH  base^exp mod mod, valid with done, held until next acceptance.

Function
REQ-012 SHALL implement a FSM with states IDLE, SQUARE, MULTIPLY, FINISH.
REQ-013 IDLE: start=1 SHALL latch base/exp/mod, set accumulator to 1, bit index to WIDTH-1, clear err, and go to SQUARE; on error go directly to FINISH.
REQ-014 Operand error: mod<2 or base>=mod. It SHALL set err=1 and result=0, with done asserted 1 cycle after acceptance.
REQ-015 SHALL process exponent bits MSB-first. Per bit: SQUARE (acc=acc*acc mod m), then MULTIPLY (acc=acc*base mod m) only if the bit is 1.
REQ-016 Each modular multiply SHALL take exactly WIDTH cycles. Use interleaved shift-add: per cycle acc'=2*acc+a_i*b, then at most two conditional subtractions of m. Internal width is WIDTH+2 bits.
REQ-017 After bit 0 completes, the FSM SHALL go to FINISH. FINISH SHALL drive result=acc and done=1 for one cycle, then return to IDLE.
REQ-018 Latency from the edge that accepts start to done high SHALL be WIDTH*(WIDTH+popcount(exp))+1 cycles (macro absent).
REQ-019 exp=0 SHALL yield result=1.
REQ-020 start while busy SHALL be ignored, with no effect on state or outputs.
REQ-021 start high in the FINISH cycle SHALL be ignored. It is accepted only in a later IDLE cycle.
REQ-022 All intermediate values SHALL remain strictly less than mod. No wrap-around is permitted for any WIDTH.

Reset
REQ-023 rst SHALL asynchronously force IDLE, busy=0, done=0, err=0, result=0, and clear internal registers.
REQ-024 rst during any state SHALL abort the operation without a done pulse. The first start after rst release is accepted normally.

Configuration
REQ-025 Macro MOD_EXP_CONST_TIME_EN, when defined, SHALL execute MULTIPLY for every exponent bit. The product is discarded when the bit is 0.
REQ-026 With the macro defined, latency SHALL be fixed at 2*WIDTH*WIDTH+1 cycles regardless of exp. The error path stays at 1 cycle.
REQ-027 Without the macro, MULTIPLY SHALL be skipped for 0 bits, giving REQ-018 latency.

Structure
REQ-028 Package mod_arith_pkg SHALL hold the FSM state enum and the WIDTH legality bounds.
REQ-029 The interleaved multiplier SHALL be a sub-module mod_mult_serial. Its ports are start, a, b, m, done and p, and it shares clk and rst. It is reused for square and multiply.

Verification (WIDTH=16 unless noted)
REQ-030 base=4, exp=13, mod=497 -> result=445, err=0. done at 305 cycles without the macro, 513 cycles with it.
REQ-031 base=65, exp=17, mod=3233 -> result=2790. busy is high throughout and done is a single-cycle pulse.
REQ-032 base=7, exp=0, mod=13 -> result=1. done at 257 cycles without the macro.
REQ-033 Two error cases: mod=1, and base=20 with mod=13. Each -> err=1, result=0, done 1 cycle after acceptance.
REQ-034 Reset during SQUARE of a running job, then a new start with base=4, exp=13, mod=497 -> no stale done, and result=445 with normal latency.
REQ-035 start pulsed repeatedly while busy, and again in the FINISH cycle -> only the first job runs. A second done appears only after a start in IDLE.
